// File: rtl/round_sequencer.sv
// round_sequencer: round/cycle sequencer for the shared AES/Keccak datapath.
// Mode-selectable round count, configurable cycles per round, start/busy/done
// handshake, stall, abort and first/last-round flags.
// Optional feature macro: ROUND_SEQ_PERF_EN adds o_cycle_cnt / o_stall_cnt.
module round_sequencer #(
    parameter int RND_W              = 5,
    parameter int CYC_W              = 2,
    parameter int AES128_ROUNDS      = 10,
    parameter int AES256_ROUNDS      = 14,
    parameter int KECCAK_ROUNDS      = 24,
    parameter int AES_CYC_PER_RND    = 2,
    parameter int KECCAK_CYC_PER_RND = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_stall,
    input  logic             i_abort,
    output logic             o_busy,
    output logic [1:0]       o_mode,
    output logic [RND_W-1:0] o_round,
    output logic             o_round_valid,
    output logic             o_first,
    output logic             o_last,
    output logic             o_done
`ifdef ROUND_SEQ_PERF_EN
    ,
    output logic [15:0]      o_cycle_cnt,
    output logic [15:0]      o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [RND_W-1:0] N_AES128 = RND_W'(AES128_ROUNDS);
    localparam logic [RND_W-1:0] N_AES256 = RND_W'(AES256_ROUNDS);
    localparam logic [RND_W-1:0] N_KECCAK = RND_W'(KECCAK_ROUNDS);
    localparam logic [CYC_W-1:0] CMAX_AES = CYC_W'(AES_CYC_PER_RND - 1);
    localparam logic [CYC_W-1:0] CMAX_KEC = CYC_W'(KECCAK_CYC_PER_RND - 1);

    // Round count for a latched mode (reserved mode never gets latched).
    function automatic logic [RND_W-1:0] rounds_of(input logic [1:0] mode);
        logic [RND_W-1:0] n;
        case (mode)
            2'b00:   n = N_AES128;
            2'b01:   n = N_AES256;
            2'b10:   n = N_KECCAK;
            default: n = N_AES128;
        endcase
        return n;
    endfunction

    // Last intra-round cycle index (C-1) for a latched mode.
    function automatic logic [CYC_W-1:0] cmax_of(input logic [1:0] mode);
        logic [CYC_W-1:0] c;
        case (mode)
            2'b10:   c = CMAX_KEC;
            default: c = CMAX_AES;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             valid_q, valid_d;

    logic [RND_W-1:0] n_s;
    logic [RND_W-1:0] last_idx_s;
    logic [RND_W-1:0] round_inc_s;
    logic             start_ok_s;
    logic             start_accept_s;

    assign n_s         = rounds_of(mode_q);
    assign last_idx_s  = n_s - RND_W'(1);
    assign round_inc_s = round_q + RND_W'(1);
    assign start_ok_s  = i_start && (i_mode != 2'b11);

    // Next-state, round/cycle counters and round-valid pulse; abort > stall > advance.
    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        valid_d        = 1'b0;
        start_accept_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_d        = S_RUN;
                    round_d        = '0;
                    cnt_d          = '0;
                    mode_d         = i_mode;
                    start_accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    round_d = '0;
                    cnt_d   = '0;
                end else if (i_stall) begin
                    state_d = S_RUN;
                end else if (cnt_q == cmax_of(mode_q)) begin
                    cnt_d   = '0;
                    round_d = round_inc_s;
                    valid_d = 1'b1;
                    if (round_inc_s == n_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            S_DONE: begin
                round_d = '0;
                cnt_d   = '0;
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (start_ok_s) begin
                    state_d        = S_RUN;
                    mode_d         = i_mode;
                    start_accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            round_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign o_busy        = (state_q == S_RUN);
    assign o_done        = (state_q == S_DONE);
    assign o_mode        = mode_q;
    assign o_round       = round_q;
    assign o_round_valid = valid_q;
    assign o_first       = o_busy && (round_q == '0);
    assign o_last        = o_busy && (round_q == last_idx_s);

`ifdef ROUND_SEQ_PERF_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] stl_q, stl_d;

    // Saturating RUN-cycle and stall-cycle counters, cleared by an accepted start.
    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        if (start_accept_s) begin
            cyc_d = 16'd0;
            stl_d = 16'd0;
        end else if (state_q == S_RUN) begin
            if (cyc_q != 16'hFFFF) begin
                cyc_d = cyc_q + 16'd1;
            end else begin
                cyc_d = cyc_q;
            end
            if (!i_abort && i_stall && (stl_q != 16'hFFFF)) begin
                stl_d = stl_q + 16'd1;
            end else begin
                stl_d = stl_q;
            end
        end else begin
            cyc_d = cyc_q;
            stl_d = stl_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cyc_q <= 16'd0;
            stl_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
            stl_q <= stl_d;
        end
    end

    assign o_cycle_cnt = cyc_q;
    assign o_stall_cnt = stl_q;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer: randomized and directed stimulus compared
// against a behavioural model built on elapsed-cycle arithmetic.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, abort;
    logic [1:0] mode;
    logic       busy, rvalid, first, last, done;
    logic [1:0] omode;
    logic [4:0] round;
`ifdef ROUND_SEQ_PERF_EN
    logic [15:0] cyc_cnt, stl_cnt;
`endif

    always #5 clk = ~clk;

    round_sequencer dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode),
        .i_stall(stall), .i_abort(abort), .o_busy(busy), .o_mode(omode),
        .o_round(round), .o_round_valid(rvalid), .o_first(first),
        .o_last(last), .o_done(done)
`ifdef ROUND_SEQ_PERF_EN
        , .o_cycle_cnt(cyc_cnt), .o_stall_cnt(stl_cnt)
`endif
    );

    wire [11:0] obs = {busy, omode, round, rvalid, first, last, done};

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 run, 2 done; m_e = unstalled RUN cycles elapsed.
    int m_ph, m_e, m_mode, m_cyc, m_stl;
    bit m_v;

    function automatic int n_of(int md);
        return (md == 1) ? 14 : ((md == 2) ? 24 : 10);
    endfunction

    function automatic int c_of(int md);
        return (md == 2) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_e = 0; m_mode = 0; m_v = 1'b0; m_cyc = 0; m_stl = 0;
    endtask

    task automatic model_step();
        bit ok;
        ok = start && (mode != 2'b11);
        m_v = 1'b0;
        if (m_ph == 1) begin
            if (m_cyc < 65535) m_cyc++;
            if (abort) begin
                m_ph = 0; m_e = 0;
            end else if (stall) begin
                if (m_stl < 65535) m_stl++;
            end else begin
                m_e++;
                m_v = (m_e % c_of(m_mode)) == 0;
                if (m_e == n_of(m_mode) * c_of(m_mode)) m_ph = 2;
            end
        end else if (m_ph == 2 && abort) begin
            m_ph = 0; m_e = 0;
        end else if (ok) begin
            m_ph = 1; m_e = 0; m_mode = int'(mode); m_cyc = 0; m_stl = 0;
        end else begin
            m_ph = 0; m_e = 0;
        end
    endtask

    function automatic int m_round();
        if (m_ph == 1) return m_e / c_of(m_mode);
        if (m_ph == 2) return n_of(m_mode);
        return 0;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [4:0] r;
        logic [1:0] md;
        logic       b;
        r  = 5'(m_round());
        md = 2'(m_mode);
        b  = (m_ph == 1);
        return {b, md, r, m_v, b && (r == 5'd0), b && (int'(r) == n_of(m_mode) - 1), m_ph == 2};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; mode = 2'b00;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== 12'h000) begin
                bad++; $display("FAIL reset got=%h want=%h", obs, 12'h000);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_aes128();
        int nv = 0, nd = 0, nl = 0, nb = 0;
        mode = 2'b00; start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL aes128 i=%0d got=%h want=%h", i, obs, exp_vec());
            end
            nv += int'(rvalid); nd += int'(done); nl += int'(last); nb += int'(busy);
        end
        total++;
        if (nv != 10 || nd != 1 || nl != 2 || nb != 20) begin
            bad++; $display("FAIL aes128_counts got v=%0d d=%0d l=%0d b=%0d want 10 1 2 20", nv, nd, nl, nb);
        end
        total++;
        if (round !== 5'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL aes128_after got round=%0d busy=%b want 0 0", round, busy);
        end
    endtask

    task automatic test_keccak();
        int nv = 0, nb = 0;
        mode = 2'b10; start = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tick();
            start = 1'b0;
            mode = 2'(i);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL keccak i=%0d got=%h want=%h", i, obs, exp_vec());
            end
            nv += int'(rvalid); nb += int'(busy);
        end
        total++;
        if (nv != 24 || nb != 24 || omode !== 2'b10) begin
            bad++; $display("FAIL keccak_counts got v=%0d b=%0d mode=%0d want 24 24 2", nv, nb, omode);
        end
    endtask

    task automatic test_stall();
        int ns = 0, nb = 0;
        mode = 2'b01; start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            start = 1'b0;
            stall = (m_ph == 1) && (m_round() == 5) && (ns < 3);
            ns += int'(stall);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL stall i=%0d got=%h want=%h", i, obs, exp_vec());
            end
            nb += int'(busy);
        end
        stall = 1'b0;
        total++;
        if (nb != 31) begin
            bad++; $display("FAIL stall_latency got=%0d want=31", nb);
        end
`ifdef ROUND_SEQ_PERF_EN
        total++;
        if (cyc_cnt !== 16'd31 || stl_cnt !== 16'd3) begin
            bad++; $display("FAIL perf got cyc=%0d stl=%0d want 31 3", cyc_cnt, stl_cnt);
        end
`endif
    endtask

    task automatic test_abort();
        int guard = 0, nd = 0;
        mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        while (!(m_ph == 1 && m_round() == 7) && guard < 40) begin
            tick(); guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++; $display("FAIL abort_wait got=%0d want<40", guard);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (obs !== exp_vec() || busy !== 1'b0 || round !== 5'd0) begin
            bad++; $display("FAIL abort got=%h want=%h", obs, exp_vec());
        end
        start = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            start = 1'b0;
            nd += int'(done);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL abort_rerun i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        total++;
        if (nd != 1) begin
            bad++; $display("FAIL abort_rerun_done got=%0d want=1", nd);
        end
    endtask

    task automatic test_back_to_back();
        int nd = 0, gaps = 0;
        mode = 2'b00; start = 1'b1;
        for (int i = 0; i < 42; i++) begin
            tick();
            nd += int'(done);
            gaps += int'(!busy && !done);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL b2b i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        start = 1'b0;
        total++;
        if (nd != 2 || gaps != 0) begin
            bad++; $display("FAIL b2b_counts got d=%0d gaps=%0d want 2 0", nd, gaps);
        end
        for (int i = 0; i < 4; i++) tick();
        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (obs !== exp_vec() || busy !== 1'b0) begin
            bad++; $display("FAIL mode11 got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        int guard = 0, nd = 0;
        mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        while (!(m_ph == 1 && m_round() == 12) && guard < 40) begin
            tick(); guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++; $display("FAIL areset_wait got=%0d want<40", guard);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 12'h000) begin
            bad++; $display("FAIL areset got=%h want=%h", obs, 12'h000);
        end
`ifdef ROUND_SEQ_PERF_EN
        total++;
        if (cyc_cnt !== 16'd0 || stl_cnt !== 16'd0) begin
            bad++; $display("FAIL areset_perf got=%0d %0d want 0 0", cyc_cnt, stl_cnt);
        end
`endif
        tick();
        rst_n = 1'b1;
        mode = 2'b01; start = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick();
            start = 1'b0;
            nd += int'(done);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL areset_rerun i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        total++;
        if (nd != 1) begin
            bad++; $display("FAIL areset_rerun_done got=%0d want=1", nd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 4) == 0);
            mode  = 2'($urandom_range(0, 3));
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_vec());
            end
`ifdef ROUND_SEQ_PERF_EN
            total++;
            if (int'(cyc_cnt) != m_cyc || int'(stl_cnt) != m_stl) begin
                bad++; $display("FAIL random_perf i=%0d got=%0d %0d want %0d %0d", i, cyc_cnt, stl_cnt, m_cyc, m_stl);
            end
`endif
        end
        start = 1'b0; abort = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_keccak();
        test_stall();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
